// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcode and execute-stage state definitions
package alu_pkg;

    localparam int ALU_CTRL_W = 3;

    typedef enum logic [ALU_CTRL_W-1:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_SLT = 3'b101,
        OP_MUL = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_BUSY = 2'd1,
        DONE     = 2'd2
    } exec_state_e;

endpackage

// File: rtl/iter_multiplier.sv
// rtl/iter_multiplier.sv - shift-add multiplier, one multiplier bit per step
module iter_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             step,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] acc_next;

    assign acc_next = mplier[0] ? (acc + mcand) : acc;

    // product is the post-step accumulator so the final step can retire in the same edge
    assign product = acc_next;
    assign last    = step && (count == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
        end else if (start) begin
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
            count  <= '0;
        end else if (step) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - handshaked execute stage: single-cycle ALU ops plus iterative multiply
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ALU_CTRL_W-1:0] alu_control,
    input  logic [WIDTH-1:0]      src_a,
    input  logic [WIDTH-1:0]      src_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      result,
    output logic                  zero,
    output logic                  illegal
);

    exec_state_e      state;
    exec_state_e      next_state;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ill;
    logic             is_mul;
    logic             accept;
    logic             mul_last;
    logic [WIDTH-1:0] mul_product;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             illegal_q;

    assign is_mul = (alu_control == OP_MUL);
    assign accept = in_valid && (state == IDLE);

    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (alu_control)
            OP_ADD:  alu_res = src_a + src_b;
            OP_SUB:  alu_res = src_a - src_b;
            OP_AND:  alu_res = src_a & src_b;
            OP_OR:   alu_res = src_a | src_b;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            OP_MUL:  alu_res = '0;
            default: alu_ill = 1'b1;
        endcase
    end

    iter_multiplier #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept && is_mul),
        .step    (state == MUL_BUSY),
        .a       (src_a),
        .b       (src_b),
        .last    (mul_last),
        .product (mul_product)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    next_state = is_mul ? MUL_BUSY : DONE;
                end
            end
            MUL_BUSY: begin
                if (mul_last) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // result/zero/illegal only change on an accept or multiply completion, so DONE holds them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q  <= '0;
            zero_q    <= 1'b1;
            illegal_q <= 1'b0;
        end else if (accept && !is_mul) begin
            result_q  <= alu_res;
            zero_q    <= (alu_res == '0);
            illegal_q <= alu_ill;
        end else if (mul_last) begin
            result_q  <= mul_product;
            zero_q    <= (mul_product == '0);
            illegal_q <= 1'b0;
        end
    end

    assign result  = result_q;
    assign zero    = zero_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - scoreboard bench for alu_exec_unit
module tb_alu_exec_unit;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       alu_control;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             illegal;

    alu_exec_unit #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_control (alu_control),
        .src_a       (src_a),
        .src_b       (src_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .zero        (zero),
        .illegal     (illegal)
    );

    typedef struct {
        logic [WIDTH-1:0] r;
        logic             z;
        logic             il;
        int               acc;
        int               lat;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cycle  = 0;
    logic ov_prev = 1'b0;
    logic ir_bad  = 1'b0;
    logic rnd_or  = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycle = cycle + 1;

    always @(posedge clk) begin
        if (rnd_or) begin
            #1 out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model straight from the opcode table, using full-width arithmetic
    function automatic exp_t model(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b);
        exp_t        e;
        logic [63:0] p;
        e.r   = '0;
        e.il  = 1'b0;
        e.lat = 0;
        e.acc = 0;
        case (op)
            3'b000: e.r = a + b;
            3'b001: e.r = a - b;
            3'b010: e.r = a & b;
            3'b011: e.r = a | b;
            3'b101: e.r = ($signed(a) < $signed(b)) ? 1 : 0;
            3'b111: begin
                p     = {32'd0, a} * {32'd0, b};
                e.r   = p[WIDTH-1:0];
                e.lat = WIDTH;
            end
            default: e.il = 1'b1;
        endcase
        e.z = (e.r == '0);
        return e;
    endfunction

    task automatic issue(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t e;
        int   n;
        @(posedge clk);
        #1;
        in_valid    = 1'b1;
        alu_control = op;
        src_a       = a;
        src_b       = b;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 64'(in_ready), 64'd1);
        end else begin
            e     = model(op, a, b);
            e.acc = cycle + 1;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    // Monitor: latency on each out_valid rise, values on each retire
    always @(negedge clk) begin
        if (!rst_n) begin
            ov_prev = 1'b0;
            ir_bad  = 1'b0;
        end else begin
            if (out_valid && in_ready) ir_bad = 1'b1;
            if (!out_valid && sb.size() > 0 && cycle >= sb[0].acc && in_ready) ir_bad = 1'b1;
            if (out_valid && !ov_prev && sb.size() > 0) begin
                chk("latency", 64'(cycle - sb[0].acc), 64'(sb[0].lat));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out_valid", 64'(out_valid), 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("result", 64'(result), 64'(e.r));
                    chk("zero", 64'(zero), 64'(e.z));
                    chk("illegal", 64'(illegal), 64'(e.il));
                    chk("in_ready_low_while_busy", 64'(ir_bad), 64'd0);
                    ir_bad = 1'b0;
                end
            end
            ov_prev = out_valid;
        end
    end

    initial begin
        logic [WIDTH-1:0] hr;
        logic             hz;
        logic             hi;
        logic             stale;
        int               n;

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        alu_control = 3'b000;
        src_a       = '0;
        src_b       = '0;
        repeat (3) @(negedge clk);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_result", 64'(result), 64'd0);
        chk("reset_zero", 64'(zero), 64'd1);
        chk("reset_illegal", 64'(illegal), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        issue(3'b000, 32'hFFFF_FFFF, 32'd1);
        issue(3'b001, 32'd5, 32'd7);
        issue(3'b010, 32'h0000_F0F0, 32'h0000_FF00);
        issue(3'b011, 32'h0000_000F, 32'h0000_00F0);
        issue(3'b101, 32'hFFFF_FFFF, 32'd1);
        issue(3'b101, 32'd1, 32'hFFFF_FFFF);
        issue(3'b101, 32'd3, 32'd3);
        issue(3'b111, 32'h0001_0001, 32'h0001_0001);
        issue(3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(3'b111, 32'd1234, 32'd0);
        issue(3'b100, 32'd9, 32'd9);
        issue(3'b000, 32'd2, 32'd3);
        issue(3'b110, 32'd1, 32'd1);
        issue(3'b011, 32'd0, 32'd0);
        drain();

        // Backpressure: hold the result and try to push new ops at a busy unit
        out_ready = 1'b0;
        issue(3'b001, 32'd100, 32'd58);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        hr = result;
        hz = zero;
        hi = illegal;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            in_valid    = 1'b1;
            alu_control = 3'($urandom_range(0, 7));
            src_a       = $urandom;
            src_b       = $urandom;
            @(negedge clk);
            chk("bp_result_stable", 64'(result), 64'(hr));
            chk("bp_zero_stable", 64'(zero), 64'(hz));
            chk("bp_illegal_stable", 64'(illegal), 64'(hi));
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_single_retire_ov", 64'(out_valid), 64'd0);
        chk("bp_single_retire_sb", 64'(sb.size()), 64'd0);

        // Reset in the middle of a multiply discards it
        issue(3'b111, 32'h0001_0001, 32'h0001_0001);
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        sb.delete();
        #1;
        chk("midreset_out_valid", 64'(out_valid), 64'd0);
        chk("midreset_in_ready", 64'(in_ready), 64'd1);
        chk("midreset_result", 64'(result), 64'd0);
        chk("midreset_zero", 64'(zero), 64'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        stale = 1'b0;
        repeat (45) begin
            @(negedge clk);
            if (out_valid) stale = 1'b1;
        end
        chk("no_stale_result", 64'(stale), 64'd0);

        // Randomized ops with random consumer backpressure
        rnd_or = 1'b1;
        for (int i = 0; i < 60; i++) begin
            logic [2:0]       op;
            logic [WIDTH-1:0] a;
            logic [WIDTH-1:0] b;
            op = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom_range(0, 4)) : $urandom;
            b  = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom_range(0, 4)) : $urandom;
            issue(op, a, b);
        end
        rnd_or = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Sequential execute stage that consumes the 3-bit alu_control code produced by the ALU decoder, together with two operands, and returns a registered result.
- Single-cycle ops (add, sub, and, or, slt) complete one cycle after acceptance; multiply runs as an iterative shift-add over WIDTH cycles.
- Valid/ready handshakes on both sides, so the CPU front end can stall on a busy multiply.

Parameters:
- WIDTH, 32, operand and result width in bits; multiply iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising-edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operation presented
- in_ready  output  1  unit can accept an operation this cycle
- alu_control  input  3  operation code (encoding below)
- src_a  input  WIDTH  operand A
- src_b  input  WIDTH  operand B
- out_valid  output  1  result held and valid
- out_ready  input  1  consumer takes the result
- result  output  WIDTH  registered result
- zero  output  1  result == 0, registered with result
- illegal  output  1  accepted code was unassigned; registered with result

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Encoding: ADD 000, SUB 001, AND 010, OR 011, SLT 101, MUL 111; codes 100 and 110 are illegal.
- Reset values:
  - state = IDLE; in_ready = 1.
  - out_valid = 0, result = 0, zero = 1, illegal = 0.
  - Internal accumulator, multiplicand, multiplier and counter = 0.
- States:
  - IDLE: in_ready = 1. An accept is in_valid & in_ready. MUL goes to MUL_BUSY and latches operands. Any other code computes in the same cycle, registers result/zero/illegal, and goes to DONE.
  - MUL_BUSY: in_ready = 0. Each cycle: if multiplier[0], acc += multiplicand; multiplicand <<= 1; multiplier >>= 1; count++. After the WIDTH-th iteration, result = acc (low WIDTH bits of the product) and go to DONE.
  - DONE: out_valid = 1, in_ready = 0. result, zero and illegal are held stable. When out_ready = 1, go to IDLE, where out_valid = 0 and in_ready = 1 in the next cycle.
- Latency, counting the accept edge as N:
  - Single-cycle ops: out_valid high from cycle N+1.
  - MUL: out_valid high from cycle N+1+WIDTH (N+33 for WIDTH 32).
  - Throughput for single-cycle ops is one op per two cycles; accept and retire never occur in the same cycle.
- Arithmetic:
  - ADD and SUB wrap modulo 2^WIDTH; no carry or overflow output.
  - SLT is a signed compare; the result is 1 zero-extended to WIDTH, else 0.
  - MUL is unsigned shift-add, truncated to WIDTH bits. The result is identical for signed operands in the low word.
- Illegal code: result = 0, zero = 1, illegal = 1, one-cycle latency like ALU ops. It is never silently treated as ADD.
- in_valid while in_ready = 0 is ignored, and inputs are not sampled.
- The consumer may keep out_ready high permanently. The result then pulses out_valid for exactly one cycle per op.
- Early exit: a MUL with src_b = 0 still takes the full WIDTH cycles (fixed latency); no early termination.
- Reset mid-operation (any state): return immediately to reset values. Any in-flight multiply is discarded and no out_valid is produced for it.
- zero is computed from the final registered result, including the MUL product.

Decomposition:
- Shared package alu_pkg:
  - alu_op_e enum (3-bit) with the codes above; the decoder and this unit both import it.
  - exec_state_e {IDLE, MUL_BUSY, DONE}.
  - Constant ALU_CTRL_W = 3.
- Sub-module: iter_multiplier. It holds the shift-add datapath and counter, with start/done, operands in and product out. The FSM and single-cycle ALU stay in alu_exec_unit.

Test Plan:
- Reset: assert rst_n = 0 mid-MUL at count 10, release -> out_valid = 0, in_ready = 1, result = 0, zero = 1, and no stale result appears afterwards.
- Single-cycle ops, out_ready = 1:
  - ADD 0xFFFFFFFF + 1 -> result 0, zero 1 at N+1.
  - SUB 5 - 7 -> 0xFFFFFFFE.
  - AND 0xF0F0 & 0xFF00 -> 0xF000.
  - OR 0x0F | 0xF0 -> 0xFF.
- SLT signed: -1 vs 1 -> 1; 1 vs -1 -> 0; 3 vs 3 -> 0 with zero = 1.
- MUL:
  - 0x0001_0001 * 0x0001_0001 -> 0x0002_0001 at exactly N+33, with in_ready = 0 throughout.
  - 0xFFFFFFFF * 0xFFFFFFFF -> 0x00000001.
  - 1234 * 0 -> 0, zero 1, still 33 cycles.
- Backpressure: out_ready = 0 for 5 cycles after a result -> result, zero and illegal stay stable, in_ready = 0, and in_valid pulses with new operands are ignored. Raising out_ready retires exactly one result.
- Illegal codes 100 and 110 -> illegal = 1, result = 0 at N+1; the next legal op clears illegal to 0.
